// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the 4-to-2 sequential encoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package encoder_pkg;

    localparam int N_REQ  = 4;
    localparam int CODE_W = 2;

    // Two-state handshake FSM: IDLE has nothing to offer, HOLD presents a code.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Expand a line index into its one-hot request mask.
    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] idx);
        logic [N_REQ-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/prio_enc_4x2.sv
// Combinational 4-to-2 priority encoder; bit 3 wins, any_o flags a non-zero input.
// Latency: zero cycles (pure combinational).
// Backpressure: not applicable.
module prio_enc_4x2
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0]  req_i,
    output logic [CODE_W-1:0] code_o,
    output logic              any_o
);

    // Highest set bit selects the code; an empty input encodes as 0 with any_o low.
    always_comb begin
        code_o = '0;
        any_o  = |req_i;
        if (req_i[3]) begin
            code_o = 2'd3;
        end else if (req_i[2]) begin
            code_o = 2'd2;
        end else if (req_i[1]) begin
            code_o = 2'd1;
        end
    end

endmodule

// File: rtl/encoder_4x2_seq.sv
// Captures request pulses into a pending set and presents the highest pending index as a code.
// Latency: a request sampled at an edge while idle is presented as valid code right after that edge.
// Backpressure: code and valid hold while ready is low; new requests keep accumulating in pend.
module encoder_4x2_seq
    import encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  d,
    input  logic              e,
    input  logic              ready,
    output logic [CODE_W-1:0] y,
    output logic              valid,
    output logic              ovf
);

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    pend_q,  pend_d;
    logic [CODE_W-1:0]   y_q,     y_d;
    logic                valid_q, valid_d;
    logic                ovf_q,   ovf_d;

    logic [N_REQ-1:0]    new_req;
    logic [N_REQ-1:0]    clr_mask;
    logic [N_REQ-1:0]    enc_in;
    logic [CODE_W-1:0]   enc_code;
    logic                enc_any;
    logic                accept;

    // Requests only count while capture is enabled.
    assign new_req = d & {N_REQ{e}};

    // A handshake completes only while a code is actually being presented.
    assign accept  = (state_q == HOLD) && ready;

    // The granted line leaves the pending set on acceptance; nothing is cleared otherwise.
    assign clr_mask = accept ? onehot(y_q) : '0;

    // One shared encoder operand: in IDLE this is pend|new, on an accept it is the
    // post-clear set plus new requests, so a re-request of the granted line survives.
    assign enc_in = (pend_q & ~clr_mask) | new_req;

    prio_enc_4x2 u_prio (
        .req_i  (enc_in),
        .code_o (enc_code),
        .any_o  (enc_any)
    );

    // Next-state and output-register logic for the IDLE/HOLD handshake.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        y_d     = y_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (enc_any) begin
                    pend_d  = enc_in;
                    y_d     = enc_code;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!ready) begin
                    pend_d = pend_q | new_req;
                end else if (enc_any) begin
                    // Back-to-back grant with no bubble cycle.
                    pend_d = enc_in;
                    y_d    = enc_code;
                end else begin
                    pend_d  = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Overrun is sticky: a new pulse landing on a still-pending line that is not being granted away.
    assign ovf_d = ovf_q | (|(new_req & pend_q & ~clr_mask));

    // State and output registers; reset drops everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_encoder_4x2_seq.sv
// Directed-vector bench for encoder_4x2_seq with a per-cycle reference model.
// Inputs change 1 time unit after each rising edge; the model compares on falling edges.
// Literal expectations at key points pin both the DUT and the model.
module tb_encoder_4x2_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic       e;
    logic       ready;
    logic [1:0] y;
    logic       valid;
    logic       ovf;

    int checks;
    int errors;

    encoder_4x2_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .e     (e),
        .ready (ready),
        .y     (y),
        .valid (valid),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The model tracks a set of pending line numbers, whether a grant is on offer and
    // which line it is, following the behavioural rules directly.
    bit [3:0] m_pend;
    bit       m_busy;
    int       m_code;
    bit       m_ovf;

    function automatic int highest(input bit [3:0] x);
        for (int i = 3; i >= 0; i--) begin
            if (x[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit [3:0] arrivals;
        bit [3:0] keep;
        if (!rst_n) begin
            m_pend = '0;
            m_busy = 1'b0;
            m_code = 0;
            m_ovf  = 1'b0;
        end else begin
            arrivals = e ? d : 4'b0000;
            if (!m_busy) begin
                m_pend = m_pend | arrivals;
                if (m_pend != 0) begin
                    m_busy = 1'b1;
                    m_code = highest(m_pend);
                end
            end else if (!ready) begin
                if ((arrivals & m_pend) != 0) m_ovf = 1'b1;
                m_pend = m_pend | arrivals;
            end else begin
                keep = m_pend;
                keep[m_code] = 1'b0;
                if ((arrivals & keep) != 0) m_ovf = 1'b1;
                m_pend = keep | arrivals;
                if (m_pend != 0) m_code = highest(m_pend);
                else             m_busy = 1'b0;
            end
        end
    end

    // Every cycle out of reset, outputs must match the model; y only matters while valid.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (valid !== m_busy) begin
                errors++;
                $display("FAIL model_valid t=%0t actual=%0b required=%0b", $time, valid, m_busy);
            end
            checks++;
            if (ovf !== m_ovf) begin
                errors++;
                $display("FAIL model_ovf t=%0t actual=%0b required=%0b", $time, ovf, m_ovf);
            end
            if (m_busy) begin
                checks++;
                if (int'(y) != m_code) begin
                    errors++;
                    $display("FAIL model_y t=%0t actual=%0d required=%0d", $time, y, m_code);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input int v, input int code, input int o);
        chk({nm, "_valid"}, int'(valid), v);
        if (v != 0) chk({nm, "_y"}, int'(y), code);
        chk({nm, "_ovf"}, int'(ovf), o);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        d      = 4'b0000;
        e      = 1'b0;
        ready  = 1'b0;

        // Reset state
        #2;
        chk("rst_y", int'(y), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        step();
        step();
        rst_n = 1'b1;

        // Idle after reset, d=0
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_y", int'(y), 0);
            chk("idle_valid", int'(valid), 0);
            chk("idle_ovf", int'(ovf), 0);
        end

        // Single request
        e = 1'b1; ready = 1'b1; d = 4'b0100;
        step();
        chk_out("single", 1, 2, 0);
        d = 4'b0000;
        step();
        chk_out("single_done", 0, 0, 0);

        // Priority and back-to-back
        d = 4'b1011;
        step();
        chk_out("prio_a", 1, 3, 0);
        d = 4'b0000;
        step();
        chk_out("prio_b", 1, 1, 0);
        step();
        chk_out("prio_c", 1, 0, 0);
        step();
        chk_out("prio_done", 0, 0, 0);

        // Backpressure
        ready = 1'b0; d = 4'b0001;
        step();
        chk_out("bp_grant", 1, 0, 0);
        d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("bp_hold", 1, 0, 0);
        end
        d = 4'b1000;
        step();
        chk_out("bp_pulse", 1, 0, 0);
        d = 4'b0000;
        step();
        chk_out("bp_still", 1, 0, 0);
        ready = 1'b1;
        step();
        chk_out("bp_next", 1, 3, 0);
        step();
        chk_out("bp_done", 0, 0, 0);

        // Capture disabled
        e = 1'b0; d = 4'b1111;
        step();
        chk_out("en_off_a", 0, 0, 0);
        step();
        chk_out("en_off_b", 0, 0, 0);
        d = 4'b0000; e = 1'b1;
        step();
        chk_out("en_off_c", 0, 0, 0);

        // Re-request of the granted line in its own accept cycle
        ready = 1'b0; d = 4'b0100;
        step();
        chk_out("same_grant", 1, 2, 0);
        d = 4'b0000;
        step();
        ready = 1'b1; d = 4'b0100;
        step();
        chk_out("same_regrant", 1, 2, 0);
        d = 4'b0000;
        step();
        chk_out("same_done", 0, 0, 0);

        // Overrun: re-pulse while pending and unaccepted
        ready = 1'b0; d = 4'b0100;
        step();
        chk_out("ovf_grant", 1, 2, 0);
        d = 4'b0000;
        step();
        d = 4'b0100;
        step();
        chk_out("ovf_set", 1, 2, 1);
        d = 4'b0000; ready = 1'b1;
        step();
        chk_out("ovf_drain", 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ovf_sticky", int'(ovf), 1);
        end

        // Reset in HOLD with pend=0110
        ready = 1'b0; d = 4'b0110;
        step();
        chk_out("mid_grant", 1, 2, 1);
        d = 4'b0000;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_y", int'(y), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("post_rst", 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
